// File: rtl/mem_wb_pipe.sv
// MEM/WB pipeline register with stall hold, bubble insertion and flush.
// It also counts the instructions that enter write-back.
module mem_wb_pipe #(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned ADDR_W    = 5,
    parameter int unsigned STALL_W   = 6,
    parameter int unsigned STAGE_IDX = 4,
    parameter int unsigned CNT_W     = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [STALL_W-1:0] stall,
    input  logic               flush,
    input  logic               mem_valid,
    input  logic               mem_wreg,
    input  logic [ADDR_W-1:0]  mem_wd,
    input  logic [DATA_W-1:0]  mem_wdata,
    input  logic               mem_whilo,
    input  logic [DATA_W-1:0]  mem_hi,
    input  logic [DATA_W-1:0]  mem_lo,
    input  logic               mem_llbit_we,
    input  logic               mem_llbit_value,
    output logic               wb_valid,
    output logic               wb_wreg,
    output logic [ADDR_W-1:0]  wb_wd,
    output logic [DATA_W-1:0]  wb_wdata,
    output logic               wb_whilo,
    output logic [DATA_W-1:0]  wb_hi,
    output logic [DATA_W-1:0]  wb_lo,
    output logic               wb_llbit_we,
    output logic               wb_llbit_value,
    output logic [CNT_W-1:0]   retired
);

    logic w_s_mem;
    logic w_s_wb;
    logic w_clear;
    logic w_load;

    assign w_s_mem = stall[STAGE_IDX];
    assign w_s_wb  = stall[STAGE_IDX+1];
    // Bubble shares the clear path with reset and flush.
    assign w_clear = rst || flush || (w_s_mem && !w_s_wb);
    assign w_load  = !w_s_mem;

    logic              r_valid;
    logic              r_wreg;
    logic [ADDR_W-1:0] r_wd;
    logic [DATA_W-1:0] r_wdata;
    logic              r_whilo;
    logic [DATA_W-1:0] r_hi;
    logic [DATA_W-1:0] r_lo;
    logic              r_llbit_we;
    logic              r_llbit_value;
    logic [CNT_W-1:0]  r_retired;

    always_ff @(posedge clk) begin
        if (w_clear) begin
            r_valid       <= 1'b0;
            r_wreg        <= 1'b0;
            r_wd          <= '0;
            r_wdata       <= '0;
            r_whilo       <= 1'b0;
            r_hi          <= '0;
            r_lo          <= '0;
            r_llbit_we    <= 1'b0;
            r_llbit_value <= 1'b0;
        end else if (w_load) begin
            r_valid       <= mem_valid;
            r_wreg        <= mem_wreg;
            r_wd          <= mem_wd;
            r_wdata       <= mem_wdata;
            r_whilo       <= mem_whilo;
            r_hi          <= mem_hi;
            r_lo          <= mem_lo;
            r_llbit_we    <= mem_llbit_we;
            r_llbit_value <= mem_llbit_value;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_retired <= '0;
        end else if (!flush && w_load && mem_valid) begin
            r_retired <= r_retired + 1'b1;
        end
    end

    assign wb_valid       = r_valid;
    assign wb_wreg        = r_wreg;
    assign wb_wd          = r_wd;
    assign wb_wdata       = r_wdata;
    assign wb_whilo       = r_whilo;
    assign wb_hi          = r_hi;
    assign wb_lo          = r_lo;
    assign wb_llbit_we    = r_llbit_we;
    assign wb_llbit_value = r_llbit_value;
    assign retired        = r_retired;

endmodule

// File: tb/tb_mem_wb_pipe.sv
// Directed bench for mem_wb_pipe: default instance plus a CNT_W=4 instance
// sharing the same stimulus to exercise counter wrap.
module tb_mem_wb_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  stall;
    logic        flush;
    logic        mem_valid;
    logic        mem_wreg;
    logic [4:0]  mem_wd;
    logic [31:0] mem_wdata;
    logic        mem_whilo;
    logic [31:0] mem_hi;
    logic [31:0] mem_lo;
    logic        mem_llbit_we;
    logic        mem_llbit_value;

    logic        wb_valid, wb_wreg, wb_whilo, wb_llbit_we, wb_llbit_value;
    logic [4:0]  wb_wd;
    logic [31:0] wb_wdata, wb_hi, wb_lo;
    logic [31:0] retired;

    logic        n_valid, n_wreg, n_whilo, n_llbit_we, n_llbit_value;
    logic [4:0]  n_wd;
    logic [31:0] n_wdata, n_hi, n_lo;
    logic [3:0]  retired4;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mem_wb_pipe u_dut (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall),
        .flush           (flush),
        .mem_valid       (mem_valid),
        .mem_wreg        (mem_wreg),
        .mem_wd          (mem_wd),
        .mem_wdata       (mem_wdata),
        .mem_whilo       (mem_whilo),
        .mem_hi          (mem_hi),
        .mem_lo          (mem_lo),
        .mem_llbit_we    (mem_llbit_we),
        .mem_llbit_value (mem_llbit_value),
        .wb_valid        (wb_valid),
        .wb_wreg         (wb_wreg),
        .wb_wd           (wb_wd),
        .wb_wdata        (wb_wdata),
        .wb_whilo        (wb_whilo),
        .wb_hi           (wb_hi),
        .wb_lo           (wb_lo),
        .wb_llbit_we     (wb_llbit_we),
        .wb_llbit_value  (wb_llbit_value),
        .retired         (retired)
    );

    mem_wb_pipe #(.CNT_W(4)) u_dut4 (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall),
        .flush           (flush),
        .mem_valid       (mem_valid),
        .mem_wreg        (mem_wreg),
        .mem_wd          (mem_wd),
        .mem_wdata       (mem_wdata),
        .mem_whilo       (mem_whilo),
        .mem_hi          (mem_hi),
        .mem_lo          (mem_lo),
        .mem_llbit_we    (mem_llbit_we),
        .mem_llbit_value (mem_llbit_value),
        .wb_valid        (n_valid),
        .wb_wreg         (n_wreg),
        .wb_wd           (n_wd),
        .wb_wdata        (n_wdata),
        .wb_whilo        (n_whilo),
        .wb_hi           (n_hi),
        .wb_lo           (n_lo),
        .wb_llbit_we     (n_llbit_we),
        .wb_llbit_value  (n_llbit_value),
        .retired         (retired4)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic chk_wb(input string tag, input logic v, input logic wreg,
                          input logic [4:0] wd, input logic [31:0] wdata,
                          input logic whilo, input logic [31:0] hi, input logic [31:0] lo,
                          input logic llwe, input logic llv, input logic [31:0] ret,
                          input logic [3:0] ret4);
        chk({tag, ".valid"},   32'(wb_valid),       32'(v));
        chk({tag, ".wreg"},    32'(wb_wreg),        32'(wreg));
        chk({tag, ".wd"},      32'(wb_wd),          32'(wd));
        chk({tag, ".wdata"},   wb_wdata,            wdata);
        chk({tag, ".whilo"},   32'(wb_whilo),       32'(whilo));
        chk({tag, ".hi"},      wb_hi,               hi);
        chk({tag, ".lo"},      wb_lo,               lo);
        chk({tag, ".llwe"},    32'(wb_llbit_we),    32'(llwe));
        chk({tag, ".llv"},     32'(wb_llbit_value), 32'(llv));
        chk({tag, ".retired"}, retired,             ret);
        chk({tag, ".ret4"},    32'(retired4),       32'(ret4));
        chk({tag, ".n_wdata"}, n_wdata,             wdata);
    endtask

    task automatic set_mem(input logic v, input logic wreg, input logic [4:0] wd,
                           input logic [31:0] wdata, input logic whilo,
                           input logic [31:0] hi, input logic [31:0] lo,
                           input logic llwe, input logic llv);
        mem_valid       = v;
        mem_wreg        = wreg;
        mem_wd          = wd;
        mem_wdata       = wdata;
        mem_whilo       = whilo;
        mem_hi          = hi;
        mem_lo          = lo;
        mem_llbit_we    = llwe;
        mem_llbit_value = llv;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset with every input nonzero.
        rst   = 1'b1;
        flush = 1'b0;
        stall = 6'b000000;
        set_mem(1, 1, 5'd31, 32'hAAAA5555, 1, 32'h11112222, 32'h33334444, 1, 1);
        tick();
        tick();
        chk_wb("reset", 0, 0, 5'd0, 32'h0, 0, 32'h0, 32'h0, 0, 0, 32'd0, 4'd0);

        // First pass after release.
        rst = 1'b0;
        set_mem(1, 1, 5'd3, 32'hDEADBEEF, 0, 32'h0, 32'h0, 0, 0);
        tick();
        chk_wb("pass1", 1, 1, 5'd3, 32'hDEADBEEF, 0, 32'h0, 32'h0, 0, 0, 32'd1, 4'd1);

        // Hold for three edges while MEM changes.
        stall = 6'b111111;
        set_mem(1, 0, 5'd7, 32'h12345678, 1, 32'h9, 32'h8, 1, 0);
        tick();
        chk_wb("hold1", 1, 1, 5'd3, 32'hDEADBEEF, 0, 32'h0, 32'h0, 0, 0, 32'd1, 4'd1);
        set_mem(1, 1, 5'd8, 32'h87654321, 1, 32'h7, 32'h6, 0, 1);
        tick();
        chk_wb("hold2", 1, 1, 5'd3, 32'hDEADBEEF, 0, 32'h0, 32'h0, 0, 0, 32'd1, 4'd1);
        tick();
        chk_wb("hold3", 1, 1, 5'd3, 32'hDEADBEEF, 0, 32'h0, 32'h0, 0, 0, 32'd1, 4'd1);

        // Stall boundary between MEM and WB: one bubble, no retire.
        stall = 6'b011111;
        tick();
        chk_wb("bubble", 0, 0, 5'd0, 32'h0, 0, 32'h0, 32'h0, 0, 0, 32'd1, 4'd1);

        // Load something, then flush under a full stall.
        stall = 6'b000000;
        set_mem(1, 1, 5'd9, 32'h00000055, 1, 32'h5, 32'h6, 1, 1);
        tick();
        chk_wb("prefl", 1, 1, 5'd9, 32'h00000055, 1, 32'h5, 32'h6, 1, 1, 32'd2, 4'd2);
        flush = 1'b1;
        stall = 6'b111111;
        tick();
        chk_wb("flush", 0, 0, 5'd0, 32'h0, 0, 32'h0, 32'h0, 0, 0, 32'd2, 4'd2);
        flush = 1'b0;

        // HI/LO and LLbit; disabled GPR write with nonzero data still passes.
        stall = 6'b000000;
        set_mem(1, 0, 5'd0, 32'hCAFEF00D, 1, 32'h00000001, 32'hFFFFFFFF, 1, 1);
        tick();
        chk_wb("hilo", 1, 0, 5'd0, 32'hCAFEF00D, 1, 32'h1, 32'hFFFFFFFF, 1, 1, 32'd3, 4'd3);

        // Counter wrap: 17 valid passes with 3 invalid ones interleaved.
        rst = 1'b1;
        tick();
        chk_wb("rst2", 0, 0, 5'd0, 32'h0, 0, 32'h0, 32'h0, 0, 0, 32'd0, 4'd0);
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (i == 4 || i == 9 || i == 15) begin
                set_mem(0, 1, 5'd2, 32'h100 + 32'(i), 0, 32'h0, 32'h0, 0, 0);
            end else begin
                set_mem(1, 1, 5'd1, 32'h200 + 32'(i), 0, 32'h0, 32'h0, 0, 0);
            end
            tick();
        end
        chk_wb("wrap", 1, 1, 5'd1, 32'h213, 0, 32'h0, 32'h0, 0, 0, 32'd17, 4'd1);
        set_mem(0, 1, 5'd12, 32'h0BADF00D, 1, 32'h3, 32'h4, 0, 1);
        tick();
        chk_wb("invpass", 0, 1, 5'd12, 32'h0BADF00D, 1, 32'h3, 32'h4, 0, 1, 32'd17, 4'd1);

        // Reset in the middle of a hold.
        set_mem(1, 1, 5'd4, 32'h00000044, 0, 32'h0, 32'h0, 0, 0);
        tick();
        chk_wb("premh", 1, 1, 5'd4, 32'h44, 0, 32'h0, 32'h0, 0, 0, 32'd18, 4'd2);
        stall = 6'b111111;
        set_mem(1, 1, 5'd5, 32'h00000055, 0, 32'h0, 32'h0, 0, 0);
        tick();
        chk_wb("mhold", 1, 1, 5'd4, 32'h44, 0, 32'h0, 32'h0, 0, 0, 32'd18, 4'd2);
        rst = 1'b1;
        tick();
        chk_wb("mhrst", 0, 0, 5'd0, 32'h0, 0, 32'h0, 32'h0, 0, 0, 32'd0, 4'd0);
        rst   = 1'b0;
        stall = 6'b000000;
        set_mem(1, 1, 5'd6, 32'h00000066, 1, 32'hA, 32'hB, 1, 0);
        tick();
        chk_wb("postrst", 1, 1, 5'd6, 32'h66, 1, 32'hA, 32'hB, 1, 0, 32'd1, 4'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
